// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit feeding the PC register and IF/ID registers.
// Arbitrates jump requests (interrupt over execute), merges stall requests into
// one encoded hold level, enforces a post-jump flush window and counts stalled
// cycles. The optional bus-stall watchdog is built when PIPE_CTRL_BUS_WDT_EN is
// defined; otherwise bus_timeout_o is tied low and timeout_clr_i is ignored.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned BUS_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_ex_i,
    input  logic [31:0] jump_addr_ex_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_req_ex_i,
    input  logic        hold_req_clint_i,
    input  logic        hold_req_bus_i,
    input  logic        timeout_clr_i,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_flag_o,
    output logic [31:0] stall_cycles_o,
    output logic        bus_timeout_o
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam bit         FLUSH_EN   = (FLUSH_CYCLES != 0);
    localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [31:0] stall_cnt;
    logic        jump_any;

    assign jump_any       = int_assert_i | jump_req_ex_i;
    assign stall_cycles_o = stall_cnt;

    // Jump arbitration and hold-level merge; everything forced to zero while in reset
    always_comb begin
        jump_flag_o = 1'b0;
        jump_addr_o = 32'd0;
        hold_flag_o = HOLD_NONE;
        if (!rst) begin
            jump_flag_o = jump_any;
            if (int_assert_i) begin
                jump_addr_o = int_addr_i;
            end else if (jump_req_ex_i) begin
                jump_addr_o = jump_addr_ex_i;
            end
            if (jump_any || hold_req_ex_i || hold_req_clint_i || (state == FLUSH)) begin
                hold_flag_o = HOLD_ID;
            end else if (hold_req_bus_i) begin
                hold_flag_o = HOLD_PC;
            end
        end
    end

    // Flush-window FSM: a jump (re)arms FLUSH_CYCLES extra cycles of Hold_Id
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_any && FLUSH_EN) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (jump_any) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (flush_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Count every cycle that presents a non-zero hold level; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (hold_flag_o != HOLD_NONE) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

`ifdef PIPE_CTRL_BUS_WDT_EN
    localparam logic [15:0] BUS_LIMIT = 16'(BUS_TIMEOUT);
    localparam logic [15:0] BUS_LAST  = 16'(BUS_TIMEOUT - 1);

    logic [15:0] bus_cnt;

    // Bus-stall watchdog: saturating run-length counter with a sticky flag, set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_cnt       <= 16'd0;
            bus_timeout_o <= 1'b0;
        end else begin
            if (!hold_req_bus_i) begin
                bus_cnt <= 16'd0;
            end else if (bus_cnt != BUS_LIMIT) begin
                bus_cnt <= bus_cnt + 16'd1;
            end
            if (hold_req_bus_i && (bus_cnt == BUS_LAST)) begin
                bus_timeout_o <= 1'b1;
            end else if (timeout_clr_i) begin
                bus_timeout_o <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_clr;

    assign unused_timeout_clr = timeout_clr_i;
    assign bus_timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl with a queue-based scoreboard.
// Two instances share the stimulus: dut (FLUSH_CYCLES=3) and dut1 (FLUSH_CYCLES=1),
// both with BUS_TIMEOUT=8. Watchdog expectations follow PIPE_CTRL_BUS_WDT_EN.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_req_ex_i;
    logic [31:0] jump_addr_ex_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;
    logic        hold_req_ex_i;
    logic        hold_req_clint_i;
    logic        hold_req_bus_i;
    logic        timeout_clr_i;

    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic [31:0] stall_cycles_o;
    logic        bus_timeout_o;

    logic        jump_flag1;
    logic [31:0] jump_addr1;
    logic [2:0]  hold_flag1;
    logic [31:0] stall_cycles1;
    logic        bus_timeout1;

`ifdef PIPE_CTRL_BUS_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  hf;
        logic [2:0]  hf1;
        logic [31:0] sc;
        logic        bt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pipe_ctrl #(.FLUSH_CYCLES(3), .BUS_TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .jump_req_ex_i    (jump_req_ex_i),
        .jump_addr_ex_i   (jump_addr_ex_i),
        .int_assert_i     (int_assert_i),
        .int_addr_i       (int_addr_i),
        .hold_req_ex_i    (hold_req_ex_i),
        .hold_req_clint_i (hold_req_clint_i),
        .hold_req_bus_i   (hold_req_bus_i),
        .timeout_clr_i    (timeout_clr_i),
        .jump_flag_o      (jump_flag_o),
        .jump_addr_o      (jump_addr_o),
        .hold_flag_o      (hold_flag_o),
        .stall_cycles_o   (stall_cycles_o),
        .bus_timeout_o    (bus_timeout_o)
    );

    pipe_ctrl #(.FLUSH_CYCLES(1), .BUS_TIMEOUT(8)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .jump_req_ex_i    (jump_req_ex_i),
        .jump_addr_ex_i   (jump_addr_ex_i),
        .int_assert_i     (int_assert_i),
        .int_addr_i       (int_addr_i),
        .hold_req_ex_i    (hold_req_ex_i),
        .hold_req_clint_i (hold_req_clint_i),
        .hold_req_bus_i   (hold_req_bus_i),
        .timeout_clr_i    (timeout_clr_i),
        .jump_flag_o      (jump_flag1),
        .jump_addr_o      (jump_addr1),
        .hold_flag_o      (hold_flag1),
        .stall_cycles_o   (stall_cycles1),
        .bus_timeout_o    (bus_timeout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, report a FAIL line on disagreement
    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL vec %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        chk(e.idx, "jump_flag",    {31'd0, jump_flag_o},   {31'd0, e.jf});
        chk(e.idx, "jump_addr",    jump_addr_o,            e.ja);
        chk(e.idx, "hold_flag",    {29'd0, hold_flag_o},   {29'd0, e.hf});
        chk(e.idx, "hold_flag_fc1", {29'd0, hold_flag1},   {29'd0, e.hf1});
        chk(e.idx, "stall_cycles", stall_cycles_o,         e.sc);
        chk(e.idx, "bus_timeout",  {31'd0, bus_timeout_o}, {31'd0, e.bt & WDT});
    endtask

    // Monitor: whenever an expectation is pending, compare it mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue its expectation
    task automatic applyStimulus(
        input logic r, input logic jex, input logic [31:0] jaddr,
        input logic ia, input logic [31:0] iaddr,
        input logic hex, input logic hcl, input logic hbus, input logic clr,
        input logic ejf, input logic [31:0] eja, input logic [2:0] ehf,
        input logic [2:0] ehf1, input logic [31:0] esc, input logic ebt);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        jump_req_ex_i    = jex;
        jump_addr_ex_i   = jaddr;
        int_assert_i     = ia;
        int_addr_i       = iaddr;
        hold_req_ex_i    = hex;
        hold_req_clint_i = hcl;
        hold_req_bus_i   = hbus;
        timeout_clr_i    = clr;
        e.idx = cyc;
        e.jf  = ejf;
        e.ja  = eja;
        e.hf  = ehf;
        e.hf1 = ehf1;
        e.sc  = esc;
        e.bt  = ebt;
        exp_q.push_back(e);
        cyc++;
    endtask

    // Quiet cycle with only bus stall / clear as options
    task automatic busStep(input logic hbus, input logic clr, input logic [2:0] ehf,
                           input logic [2:0] ehf1, input logic [31:0] esc, input logic ebt);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, hbus, clr, 0, 0, ehf, ehf1, esc, ebt);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1; jump_req_ex_i = 1'b0; jump_addr_ex_i = 32'd0; int_assert_i = 1'b0;
        int_addr_i = 32'd0; hold_req_ex_i = 1'b0; hold_req_clint_i = 1'b0;
        hold_req_bus_i = 1'b0; timeout_clr_i = 1'b0;

        // Reset with active requests: outputs forced quiet
        //            rst jex addr     ia iaddr    hex hcl bus clr  jf ja        hf hf1 sc  bt
        applyStimulus(1,  1,  32'h40,  0, 32'h0,   1,  0,  0,  0,   0, 32'h0,    0, 0,  0,  0);
        applyStimulus(1,  1,  32'h40,  1, 32'h80,  1,  1,  1,  0,   0, 32'h0,    0, 0,  0,  0);
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   0,  0,  0,  0,   0, 32'h0,    0, 0,  0,  0);

        // Interrupt beats EX jump; flush windows of 3 and 1 cycles
        applyStimulus(0,  1,  32'h40,  1, 32'h80,  0,  0,  0,  0,   1, 32'h80,   3, 3,  0,  0);
        busStep(0, 0, 3, 3, 1, 0);
        busStep(0, 0, 3, 0, 2, 0);
        busStep(0, 0, 3, 0, 3, 0);
        busStep(0, 0, 0, 0, 4, 0);

        // Back-to-back EX jumps two cycles apart
        applyStimulus(0,  1,  32'h100, 0, 32'h0,   0,  0,  0,  0,   1, 32'h100,  3, 3,  4,  0);
        busStep(0, 0, 3, 3, 5, 0);
        applyStimulus(0,  1,  32'h200, 0, 32'h0,   0,  0,  0,  0,   1, 32'h200,  3, 3,  6,  0);
        busStep(0, 0, 3, 3, 7, 0);
        busStep(0, 0, 3, 0, 8, 0);
        busStep(0, 0, 3, 0, 9, 0);
        busStep(0, 0, 0, 0, 10, 0);

        // Hold priority merge
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   0,  0,  1,  0,   0, 32'h0,    1, 1,  10, 0);
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   1,  0,  1,  0,   0, 32'h0,    3, 3,  11, 0);
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   1,  0,  1,  0,   0, 32'h0,    3, 3,  12, 0);
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   0,  0,  1,  0,   0, 32'h0,    1, 1,  13, 0);
        busStep(0, 0, 0, 0, 14, 0);
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   0,  1,  0,  0,   0, 32'h0,    3, 3,  14, 0);
        applyStimulus(0,  0,  32'h0,   0, 32'h0,   0,  1,  1,  0,   0, 32'h0,    3, 3,  15, 0);

        // Jump during a bus stall still goes through
        applyStimulus(0,  1,  32'h44,  0, 32'h0,   0,  0,  1,  0,   1, 32'h44,   3, 3,  16, 0);
        busStep(0, 0, 3, 3, 17, 0);
        busStep(0, 0, 3, 0, 18, 0);
        busStep(0, 0, 3, 0, 19, 0);
        busStep(0, 0, 0, 0, 20, 0);

        // Watchdog: 8 consecutive bus-stall cycles trip it, sticky until clear
        for (int i = 0; i < 8; i++) busStep(1, 0, 1, 1, 32'(20 + i), 0);
        busStep(0, 0, 0, 0, 28, 1);
        busStep(0, 0, 0, 0, 28, 1);
        busStep(0, 1, 0, 0, 28, 1);
        busStep(0, 0, 0, 0, 28, 0);

        // Set and clear together: set wins
        for (int i = 0; i < 7; i++) busStep(1, 0, 1, 1, 32'(28 + i), 0);
        busStep(1, 1, 1, 1, 35, 0);
        busStep(0, 0, 0, 0, 36, 1);
        busStep(0, 1, 0, 0, 36, 1);
        busStep(0, 0, 0, 0, 36, 0);

        // Reset in the middle of a flush window: nothing owed afterwards
        applyStimulus(0,  1,  32'h300, 0, 32'h0,   0,  0,  0,  0,   1, 32'h300,  3, 3,  36, 0);
        applyStimulus(1,  1,  32'h300, 0, 32'h0,   1,  0,  0,  0,   0, 32'h0,    0, 0,  0,  0);
        busStep(0, 0, 0, 0, 0, 0);

        // Counter wrap: preload all-ones, one stalled cycle rolls it to zero
        busStep(1, 0, 1, 1, 32'hFFFF_FFFF, 0);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        busStep(0, 0, 0, 0, 0, 0);
        busStep(0, 0, 0, 0, 0, 0);

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
